ahb3lite_dma_master: RTL and testbench
======================================

# ahb3lite_dma_master

AHB-Lite write initiator for the CPU/DMA path: accepts a block-write command (start address, beat count), pulls 32-bit words from a local source, and drives word-sized write transfers on the AHB-Lite bus toward the memory-side slave. Issues SINGLE for one-beat commands and INCR bursts otherwise, honours HREADY wait states and ERROR responses, and reports completion per command. It is the bus-initiating end of the same AHB-Lite link the memory write slave terminates, and uses the `ahb3lite_pkg` types.

## Interface
- LEN_W, 8, width of `cmd_len` (beats per command; max 2^LEN_W-1)
- HCLK  in  1  bus clock; all logic on rising edge
- HRESETn  in  1  asynchronous, active-low reset
- HADDR  out  32  address-phase address
- HWDATA  out  32  data-phase write data
- HWRITE  out  1  always 1 while HTRANS is NONSEQ/SEQ/BUSY, else 0
- HBURST  out  HBURST_Type  SINGLE (cmd_len==1) or INCR
- HSIZE  out  3  fixed 3'b010 (word)
- HTRANS  out  HTRANS_state  IDLE/BUSY/NONSEQ/SEQ
- HREADY  in  1  transfer-complete / slave ready
- HRESP  in  HRESP_state  OKAY/ERROR
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in state S_IDLE
- cmd_addr  in  32  word-aligned start address (bits[1:0] ignored, forced 0)
- cmd_len  in  LEN_W  beat count
- src_valid  in  1  src_data holds a word
- src_data  in  32  next write word
- src_pop  out  1  word consumed this cycle
- done  out  1  one-cycle pulse, command finished
- err  out  1  valid with done; 1 if ERROR response terminated the command

## Operation
- Reset values: HADDR=0, HWDATA=0, HWRITE=0, HBURST=SINGLE, HSIZE=3'b010, HTRANS=IDLE, cmd_ready=0 during reset then 1, src_pop=0, done=0, err=0; beat counter and address register 0.
- States: S_IDLE, S_XFER, S_LAST, S_ERR.
- S_IDLE: cmd_valid&&cmd_ready latches addr/len -> S_XFER. cmd_len==0: no bus activity, done=1, err=0 next cycle, stay S_IDLE.
- S_XFER: drives beats. A beat's address phase is presented only when src_valid=1; it is accepted on an edge with HREADY=1. At acceptance: src_pop=1 (same cycle, combinational on HTRANS active && HREADY && src_valid), src_data registered into HWDATA for the following data phase, address += 4, remaining count -= 1. First beat NONSEQ, subsequent beats SEQ. After the last beat's address is accepted -> S_LAST with HTRANS=IDLE.
- While HREADY=0: HADDR, HTRANS, HBURST, HWDATA held stable; src_pop=0.
- 1 KB boundary: INCR never crosses; when the next address has bits[9:0]==0, that beat is issued NONSEQ (new INCR burst).
- src_valid low mid-burst: see Configuration.
- S_LAST: waits for final data phase HREADY=1, then done=1, err=0 -> S_IDLE.
- ERROR: on first ERROR cycle (HRESP=ERROR, HREADY=0) HTRANS forced IDLE that cycle; -> S_ERR; next cycle (HREADY=1) done=1, err=1 -> S_IDLE. Remaining beats dropped, no further src_pop.
- Reset mid-command: all state abandoned immediately, outputs to reset values, no done.

## Timing
- Command accepted at edge T: first NONSEQ visible after T (cycle T+1).
- Zero-wait burst of N beats: address phases T+1..T+N, data phases T+2..T+N+1, done high in cycle T+N+2.
- Each wait cycle (HREADY=0) adds one cycle; each src_valid gap adds one cycle.
- cmd_ready low from acceptance through the done cycle; next command accepted earliest the cycle after done.

## Configuration
- DMA_MASTER_BUSY_EN defined: src_valid low inside an INCR burst drives HTRANS=BUSY with HADDR held at the next beat address; burst resumes with SEQ when src_valid returns.
- Not defined: src_valid low inside a burst drives HTRANS=IDLE (burst ends); when src_valid returns the next beat is issued NONSEQ INCR at the next address. BUSY is never generated.

## Test plan
- cmd_addr=0x100, cmd_len=1, src_valid=1, HREADY=1 -> one NONSEQ SINGLE, HADDR=0x100, HWDATA=src word next cycle, done at T+3, err=0.
- cmd_addr=0x200, len=4, zero wait -> NONSEQ,SEQ,SEQ,SEQ INCR at 0x200/0x204/0x208/0x20C, 4 src_pop, done at T+6.
- len=4 with HREADY=0 for 2 cycles on beat 2 -> HADDR/HTRANS/HWDATA stable during stall, done at T+8.
- cmd_addr=0x3F8, len=4 -> beats 0x3F8 NONSEQ, 0x3FC SEQ, 0x400 NONSEQ, 0x404 SEQ.
- len=4, src_valid low one cycle after beat 2 -> BUSY at 0x208 with macro, IDLE then NONSEQ at 0x208 without.
- ERROR response on beat 2 data phase -> HTRANS=IDLE in first ERROR cycle, done=1 err=1, only 3 src_pop total.

Source files
------------

// File: rtl/ahb3lite_dma_master.sv
// AHB-Lite block-write initiator: turns (addr, len) commands into SINGLE/INCR word writes fed from a local source.
// Optional feature macro: DMA_MASTER_BUSY_EN (source gaps inside a burst become BUSY instead of ending the burst).
`timescale 1ns/1ps

package ahb3lite_pkg;
    typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11} HTRANS_state;
    typedef enum logic [2:0] {SINGLE = 3'b000, INCR = 3'b001, WRAP4 = 3'b010, INCR4 = 3'b011,
                              WRAP8 = 3'b100, INCR8 = 3'b101, WRAP16 = 3'b110, INCR16 = 3'b111} HBURST_Type;
    typedef enum logic {OKAY = 1'b0, ERROR = 1'b1} HRESP_state;
endpackage

module ahb3lite_dma_master
    import ahb3lite_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    output logic [31:0]      HADDR,
    output logic [31:0]      HWDATA,
    output logic             HWRITE,
    output HBURST_Type       HBURST,
    output logic [2:0]       HSIZE,
    output HTRANS_state      HTRANS,
    input  logic             HREADY,
    input  HRESP_state       HRESP,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             src_valid,
    input  logic [31:0]      src_data,
    output logic             src_pop,
    output logic             done,
    output logic             err,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {S_IDLE = 2'b00, S_XFER = 2'b01, S_LAST = 2'b10, S_ERR = 2'b11} state_t;

    // Handshakes: cmd moves on an edge with cmd_valid && cmd_ready; a source word moves on an
    // edge with src_pop high, and src_valid must stay high until its word is popped.
    state_t           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             first_q, first_d;
    logic             hold_q, hold_d;
    HBURST_Type       burst_q, burst_d;
    logic [31:0]      hwdata_q, hwdata_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    HTRANS_state htrans_c;
    logic        eff_valid, seq_ok, beat_active, accept, err_cycle;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            first_q  <= 1'b1;
            hold_q   <= 1'b0;
            burst_q  <= SINGLE;
            hwdata_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            hold_q   <= hold_d;
            burst_q  <= burst_d;
            hwdata_q <= hwdata_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        first_d  = first_q;
        hold_d   = 1'b0;
        burst_d  = burst_q;
        hwdata_d = hwdata_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d  = cmd_addr & ~32'h3;
                    cnt_d   = cmd_len;
                    first_d = 1'b1;
                    burst_d = (cmd_len == LEN_W'(1)) ? SINGLE : INCR;
                    if (cmd_len == '0) done_d = 1'b1;
                    else               state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (err_cycle) begin
                    state_d = S_ERR;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    // A presented beat stalled by HREADY must be re-presented unchanged.
                    hold_d = beat_active && !HREADY;
                    if (accept) begin
                        hwdata_d = src_data;
                        addr_d   = addr_q + 32'd4;
                        cnt_d    = cnt_q - LEN_W'(1);
                        first_d  = 1'b0;
                        if (cnt_q == LEN_W'(1)) state_d = S_LAST;
                    end
`ifndef DMA_MASTER_BUSY_EN
                    else if (!eff_valid) first_d = 1'b1;
`endif
                end
            end
            S_LAST: begin
                if (err_cycle) begin
                    state_d = S_ERR;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else if (HREADY) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_ERR: begin
                if (HREADY) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        eff_valid = src_valid || hold_q;
        // SEQ only continues a running burst that does not cross a 1 KB boundary.
        seq_ok    = !first_q && (addr_q[9:0] != 10'd0);
        err_cycle = (HRESP == ERROR) && !HREADY && (state_q == S_XFER || state_q == S_LAST);
        htrans_c  = IDLE;
        if (state_q == S_XFER && !err_cycle) begin
            if (eff_valid) htrans_c = seq_ok ? SEQ : NONSEQ;
`ifdef DMA_MASTER_BUSY_EN
            else if (seq_ok) htrans_c = BUSY;
`endif
        end
        beat_active = (htrans_c == NONSEQ) || (htrans_c == SEQ);
        accept      = beat_active && HREADY;
    end

    assign HTRANS    = htrans_c;
    assign HADDR     = addr_q;
    assign HWDATA    = hwdata_q;
    assign HWRITE    = (htrans_c != IDLE);
    assign HBURST    = burst_q;
    assign HSIZE     = 3'b010;
    assign src_pop   = accept && src_valid;
    assign cmd_ready = HRESETn && (state_q == S_IDLE) && !done_q;
    assign done      = done_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ahb3lite_dma_master.sv
// Directed bench for ahb3lite_dma_master: per-cycle bus expectations plus a write-data scoreboard.
`timescale 1ns/1ps

module tb_ahb3lite_dma_master;
  import ahb3lite_pkg::*;

  localparam int LEN_W = 8;

  logic             HCLK = 1'b0;
  logic             HRESETn;
  logic [31:0]      HADDR;
  logic [31:0]      HWDATA;
  logic             HWRITE;
  HBURST_Type       HBURST;
  logic [2:0]       HSIZE;
  HTRANS_state      HTRANS;
  logic             HREADY;
  HRESP_state       HRESP;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic             src_valid;
  logic [31:0]      src_data;
  logic             src_pop;
  logic             done;
  logic             err;
  logic [1:0]       dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] word_n = 32'hD000_0000;
  logic [2:0]  exp_burst;

  ahb3lite_dma_master #(.LEN_W(LEN_W)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE),
    .HBURST(HBURST), .HSIZE(HSIZE), .HTRANS(HTRANS), .HREADY(HREADY), .HRESP(HRESP),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .src_valid(src_valid), .src_data(src_data), .src_pop(src_pop), .done(done), .err(err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One bus cycle, entered and left at a negedge: drive, settle, compare.
  task automatic cyc(input logic sv, input logic hr, input logic er, input logic [1:0] et,
                     input logic [31:0] ea, input logic ep, input logic ed, input logic ee);
    src_valid = sv;
    src_data  = word_n;
    word_n    = word_n + 32'h11;
    HREADY    = hr;
    HRESP     = er ? ERROR : OKAY;
    #1;
    chk("htrans", HTRANS, et);
    chk("hwrite", HWRITE, et != 2'b00);
    if (et != 2'b00) begin
      chk("haddr", HADDR, ea);
      chk("hburst", HBURST, exp_burst);
    end
    chk("src_pop", src_pop, ep);
    chk("done", done, ed);
    if (ed) begin
      chk("err", err, ee);
      chk("rdy_in_done", cmd_ready, 1'b0);
    end
    if (exp_q.size() > 0) begin
      chk("hwdata", HWDATA, exp_q[0]);
      if (hr) void'(exp_q.pop_front());
    end
    if (ep) exp_q.push_back(src_data);
    @(posedge HCLK);
    @(negedge HCLK);
  endtask

  task automatic issue(input logic [31:0] a, input logic [LEN_W-1:0] n);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = n;
    src_valid = 1'b0;
    HREADY    = 1'b1;
    HRESP     = OKAY;
    exp_burst = (n == 1) ? 3'(SINGLE) : 3'(INCR);
    #1;
    chk("cmd_ready", cmd_ready, 1'b1);
    chk("idle_trans", HTRANS, IDLE);
    @(posedge HCLK);
    @(negedge HCLK);
    cmd_valid = 1'b0;
  endtask

  task automatic drain_chk();
    chk("sb_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    HRESETn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    src_valid = 1'b0; src_data = '0; HREADY = 1'b1; HRESP = OKAY;
    exp_burst = 3'(SINGLE);
    @(negedge HCLK);
    #1;
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("rst_hwrite", HWRITE, 1'b0);
    chk("rst_hburst", HBURST, SINGLE);
    chk("rst_hsize", HSIZE, 3'b010);
    chk("rst_htrans", HTRANS, IDLE);
    chk("rst_ready", cmd_ready, 1'b0);
    chk("rst_pop", src_pop, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_state", dbg_state, 2'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);

    // single beat
    issue(32'h100, 8'd1);
    cyc(1, 1, 0, NONSEQ, 32'h100, 1, 0, 0);
    cyc(0, 1, 0, IDLE,   32'h0,   0, 0, 0);
    cyc(0, 1, 0, IDLE,   32'h0,   0, 1, 0);
    drain_chk();

    // zero-wait INCR of 4
    issue(32'h200, 8'd4);
    cyc(1, 1, 0, NONSEQ, 32'h200, 1, 0, 0);
    cyc(1, 1, 0, SEQ,    32'h204, 1, 0, 0);
    cyc(1, 1, 0, SEQ,    32'h208, 1, 0, 0);
    cyc(1, 1, 0, SEQ,    32'h20C, 1, 0, 0);
    cyc(0, 1, 0, IDLE,   32'h0,   0, 0, 0);
    cyc(0, 1, 0, IDLE,   32'h0,   0, 1, 0);
    drain_chk();

    // two wait states on beat 2
    issue(32'h303, 8'd4);
    cyc(1, 1, 0, NONSEQ, 32'h300, 1, 0, 0);
    cyc(1, 1, 0, SEQ,    32'h304, 1, 0, 0);
    cyc(1, 0, 0, SEQ,    32'h308, 0, 0, 0);
    cyc(1, 0, 0, SEQ,    32'h308, 0, 0, 0);
    cyc(1, 1, 0, SEQ,    32'h308, 1, 0, 0);
    cyc(1, 1, 0, SEQ,    32'h30C, 1, 0, 0);
    cyc(0, 1, 0, IDLE,   32'h0,   0, 0, 0);
    cyc(0, 1, 0, IDLE,   32'h0,   0, 1, 0);
    drain_chk();

    // 1 KB boundary restarts the burst
    issue(32'h3F8, 8'd4);
    cyc(1, 1, 0, NONSEQ, 32'h3F8, 1, 0, 0);
    cyc(1, 1, 0, SEQ,    32'h3FC, 1, 0, 0);
    cyc(1, 1, 0, NONSEQ, 32'h400, 1, 0, 0);
    cyc(1, 1, 0, SEQ,    32'h404, 1, 0, 0);
    cyc(0, 1, 0, IDLE,   32'h0,   0, 0, 0);
    cyc(0, 1, 0, IDLE,   32'h0,   0, 1, 0);
    drain_chk();

    // source gap before beat 2
    issue(32'h200, 8'd4);
    cyc(1, 1, 0, NONSEQ, 32'h200, 1, 0, 0);
    cyc(1, 1, 0, SEQ,    32'h204, 1, 0, 0);
`ifdef DMA_MASTER_BUSY_EN
    cyc(0, 1, 0, BUSY,   32'h208, 0, 0, 0);
    cyc(1, 1, 0, SEQ,    32'h208, 1, 0, 0);
`else
    cyc(0, 1, 0, IDLE,   32'h0,   0, 0, 0);
    cyc(1, 1, 0, NONSEQ, 32'h208, 1, 0, 0);
`endif
    cyc(1, 1, 0, SEQ,    32'h20C, 1, 0, 0);
    cyc(0, 1, 0, IDLE,   32'h0,   0, 0, 0);
    cyc(0, 1, 0, IDLE,   32'h0,   0, 1, 0);
    drain_chk();

    // ERROR on beat 2 data phase
    issue(32'h500, 8'd4);
    cyc(1, 1, 0, NONSEQ, 32'h500, 1, 0, 0);
    cyc(1, 1, 0, SEQ,    32'h504, 1, 0, 0);
    cyc(1, 1, 0, SEQ,    32'h508, 1, 0, 0);
    cyc(1, 0, 1, IDLE,   32'h0,   0, 0, 0);
    cyc(1, 1, 1, IDLE,   32'h0,   0, 1, 1);
    cyc(1, 1, 0, IDLE,   32'h0,   0, 0, 0);
    drain_chk();

    // zero-length command
    issue(32'h600, 8'd0);
    cyc(1, 1, 0, IDLE,   32'h0,   0, 1, 0);
    cyc(1, 1, 0, IDLE,   32'h0,   0, 0, 0);

    // reset mid-command
    issue(32'h700, 8'd4);
    cyc(1, 1, 0, NONSEQ, 32'h700, 1, 0, 0);
    HRESETn = 1'b0;
    #1;
    chk("mid_rst_htrans", HTRANS, IDLE);
    chk("mid_rst_haddr", HADDR, 32'h0);
    chk("mid_rst_hwdata", HWDATA, 32'h0);
    chk("mid_rst_hburst", HBURST, SINGLE);
    chk("mid_rst_pop", src_pop, 1'b0);
    chk("mid_rst_ready", cmd_ready, 1'b0);
    exp_q.delete();
    @(negedge HCLK);
    HRESETn = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, IDLE, 32'h0, 0, 0, 0);
    #1;
    chk("post_rst_ready", cmd_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
